// File: rtl/uncached_wbuf.sv
// uncached_wbuf: in-order write buffer for uncached stores, drained one at a time as single-beat AXI writes.
// Define WBUF_MERGE_EN to let a store merge into the last-pushed entry instead of allocating a new one.
module uncached_wbuf #(
  parameter int         DEPTH  = 4,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [31:0] query_addr,
  output logic        query_hit,
  output logic        empty,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RESP} state_t;

  state_t           state;
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             push, pop, merge;
  logic [31:0]      load_data;
  logic [3:0]       load_strb;
  logic             unused_ok;

  assign unused_ok = ^{wr_addr[1:0], bid, bresp};

  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;

  assign pop   = (state == S_RESP) && bvalid;
  assign push  = wr_valid && wr_ready && !merge;
  assign empty = (count == '0) && (state == S_IDLE);

`ifdef WBUF_MERGE_EN
  logic [PW-1:0] last;
  logic [31:0]   merged_data;
  logic [3:0]    merged_strb;

  assign last = tail - 1'b1;

  always_comb begin
    merged_data = data_q[last];
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) merged_data[8*b +: 8] = wr_data[8*b +: 8];
  end

  assign merged_strb = strb_q[last] | wr_strb;

  // An issued head is frozen; a head still in IDLE may merge, so the merged word is forwarded to the load.
  assign merge = wr_valid && wr_ready && (count != '0) &&
                 (addr_q[last] == wr_addr[31:2]) &&
                 !((last == head) && (state != S_IDLE));
  assign load_data = (merge && (last == head)) ? merged_data : data_q[head];
  assign load_strb = (merge && (last == head)) ? merged_strb : strb_q[head];
`else
  assign merge     = 1'b0;
  assign load_data = data_q[head];
  assign load_strb = strb_q[head];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= wr_addr[31:2];
      data_q[tail] <= wr_data;
      strb_q[tail] <= wr_strb;
    end
`ifdef WBUF_MERGE_EN
    else if (merge) begin
      data_q[last] <= merged_data;
      strb_q[last] <= merged_strb;
    end
`endif
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && (addr_q[i] == query_addr[31:2])) query_hit = 1'b1;
  end

  // head == tail with a push and pop together cannot happen: push needs !full, pop needs count != 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid_q  <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push) begin
        tail          <= tail + 1'b1;
        valid_q[tail] <= 1'b1;
      end
      if (pop) begin
        head          <= head + 1'b1;
        valid_q[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          count    <= count + 1'b1;
          wr_ready <= (count + 1'b1) != CW'(DEPTH);
        end
        2'b01: begin
          count    <= count - 1'b1;
          wr_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            awaddr  <= {addr_q[head], 2'b00};
            wdata   <= load_data;
            wstrb   <= load_strb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uncached_wbuf.sv
// Bench for uncached_wbuf: directed scenarios plus random traffic against a queue-based reference model.
// Expectations follow WBUF_MERGE_EN when the bench is compiled with it.
module tb_uncached_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data, query_addr;
  logic [3:0]  wr_strb;
  logic        query_hit, empty;
  logic [3:0]  awid, wid, bid, awcache, wstrb;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  uncached_wbuf #(.DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .query_addr(query_addr), .query_hit(query_hit), .empty(empty),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t        q[$];
  bit          aw_got, w_got, issued;
  int          aw_pct, w_pct, b_pct;
  int          n_cmp = 0, n_err = 0, n_aw = 0;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive slave, compare against model, advance model as the coming edge will.
  task automatic step(output bit acc);
    bit aw_hs, w_hs, b_hs, exp_hit, full_pre, mrg;
    int sz;
    ent_t e;
    awready = (int'($urandom_range(0, 99)) < aw_pct);
    wready  = (int'($urandom_range(0, 99)) < w_pct);
    if (aw_got && w_got) begin
      if (!bvalid) bvalid = (int'($urandom_range(0, 99)) < b_pct);
    end else begin
      bvalid = 1'b0;
    end
    #1;
    sz = q.size();
    full_pre = (sz == DEPTH);
    check("wr_ready", wr_ready, !full_pre);
    check("empty", empty, sz == 0);
    exp_hit = 0;
    foreach (q[i]) if (q[i].addr == query_addr[31:2]) exp_hit = 1;
    check("query_hit", query_hit, exp_hit);
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    b_hs  = bvalid && bready;
    if (aw_hs) begin
      check("aw_expected", !aw_got && sz != 0, 1);
      if (sz != 0) begin
        check("awaddr", awaddr, {q[0].addr, 2'b00});
        check("aw_fixed", {awid, awlen, awsize, awburst, awlock, awcache, awprot},
              {4'd1, 8'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
      end
      aw_got = 1;
      n_aw++;
    end
    if (w_hs) begin
      check("w_expected", !w_got && sz != 0, 1);
      if (sz != 0) begin
        check("wdata", wdata, q[0].data);
        check("wstrb", wstrb, q[0].strb);
        check("w_fixed", {wid, wlast}, {4'd1, 1'b1});
      end
      last_wdata = wdata;
      last_wstrb = wstrb;
      w_got = 1;
    end
    mrg = 0;
`ifdef WBUF_MERGE_EN
    if (wr_valid && !full_pre && sz != 0 && q[sz-1].addr == wr_addr[31:2] && !(sz == 1 && issued))
      mrg = 1;
`endif
    acc = wr_valid && !full_pre;
    if (mrg) begin
      e = q[sz-1];
      for (int b = 0; b < 4; b++) if (wr_strb[b]) e.data[8*b +: 8] = wr_data[8*b +: 8];
      e.strb = e.strb | wr_strb;
      q[sz-1] = e;
    end
    if (b_hs) begin
      check("b_after_aw_w", aw_got && w_got, 1);
      if (q.size() != 0) void'(q.pop_front());
      aw_got = 0;
      w_got  = 0;
      issued = 0;
    end else if (sz != 0) begin
      issued = 1;
    end
    if (acc && !mrg) q.push_back({wr_addr[31:2], wr_data, wr_strb});
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc;
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    do begin step(acc); n++; end while (!acc && n < 200);
    check("push_timeout", acc, 1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_got();
    bit acc;
    int n = 0;
    while (!(aw_got && w_got) && n < 200) begin step(acc); n++; end
    check("got_timeout", aw_got && w_got, 1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    aw_pct = 100; w_pct = 100; b_pct = 100;
    while (q.size() != 0 && n < 1000) begin step(acc); n++; end
    check("drain_timeout", q.size() == 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    q.delete();
    aw_got = 0; w_got = 0; issued = 0;
    #1;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_empty", empty, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_query_hit", query_hit, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n0, n;
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = 4'h0;
    query_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    bid = 4'd0; bresp = 2'd0;
    aw_pct = 100; w_pct = 100; b_pct = 100;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_ready0", wr_ready, 1);
    check("rst_empty0", empty, 1);
    check("rst_query_hit0", query_hit, 0);
    check("rst_valids0", {awvalid, wvalid, bready}, 3'b000);
    check("rst_payload0", {awaddr, wdata, wstrb}, 68'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single store, latency, query hit while waiting on B
    query_addr = 32'h1FAF_0006;
    aw_pct = 100; w_pct = 100; b_pct = 0;
    n0 = n_aw;
    push(32'h1FAF_0004, 32'hDEAD_BEEF, 4'hF);
    check("lat_n1_awvalid", awvalid, 0);
    step(acc);
    check("lat_n2_awvalid", awvalid, 1);
    check("lat_n2_wvalid", wvalid, 1);
    wait_got();
    check("resp_bready", bready, 1);
    check("hit_pending", query_hit, 1);
    check("single_awaddr", awaddr, 32'h1FAF_0004);
    check("single_wdata", last_wdata, 32'hDEAD_BEEF);
    drain();
    #1;
    check("hit_after_pop", query_hit, 0);
    check("single_empty", empty, 1);
    check("single_count", n_aw - n0, 1);
    @(negedge clk);

    // fill to DEPTH with AW stalled
    aw_pct = 0; w_pct = 100; b_pct = 100;
    for (int i = 0; i < DEPTH; i++) push(32'h2000_0000 + 32'(i * 4), $urandom, 4'hF);
    check("full_wr_ready", wr_ready, 0);
    wr_valid = 1'b1; wr_addr = 32'h2000_0040; wr_data = 32'h5555_AAAA; wr_strb = 4'hF;
    repeat (3) begin step(acc); check("fifth_rejected", acc, 0); end
    wr_valid = 1'b0;
    aw_pct = 100;
    n = 0;
    while (q.size() == DEPTH && n < 200) begin step(acc); n++; end
    check("first_b_timeout", q.size() < DEPTH, 1);
    check("ready_after_b", wr_ready, 1);
    drain();

    // W delayed behind AW
    aw_pct = 100; w_pct = 0; b_pct = 100;
    n0 = n_aw;
    push(32'h0000_3000, 32'h1234_5678, 4'h6);
    n = 0;
    while (!aw_got && n < 50) begin step(acc); n++; end
    check("aw_first_timeout", aw_got, 1);
    repeat (3) step(acc);
    check("w_held_wvalid", wvalid, 1);
    check("w_held_awvalid", awvalid, 0);
    check("w_held_empty", empty, 0);
    drain();
    check("w_delay_count", n_aw - n0, 1);

    // merge scenario
    aw_pct = 0; w_pct = 100; b_pct = 100;
    n0 = n_aw;
    push(32'h0000_0100, 32'h0000_00AA, 4'h1);
    repeat (2) step(acc);
    push(32'h0000_0104, 32'h0000_00CC, 4'h1);
    push(32'h0000_0104, 32'h0000_BB00, 4'h2);
    drain();
`ifdef WBUF_MERGE_EN
    check("merge_writes", n_aw - n0, 2);
    check("merge_wdata", last_wdata, 32'h0000_BBCC);
    check("merge_wstrb", last_wstrb, 4'h3);
`else
    check("merge_writes", n_aw - n0, 3);
    check("merge_wdata", last_wdata, 32'h0000_BB00);
    check("merge_wstrb", last_wstrb, 4'h2);
`endif

    // reset while in RESP with two more queued
    aw_pct = 100; w_pct = 100; b_pct = 0;
    query_addr = 32'h3000_0004;
    for (int i = 0; i < 3; i++) push(32'h3000_0000 + 32'(i * 4), $urandom, 4'hF);
    wait_got();
    check("pre_rst_bready", bready, 1);
    do_reset();
    repeat (5) step(acc);

    // random traffic
    for (int r = 0; r < 8; r++) begin
      aw_pct = int'($urandom_range(30, 100));
      w_pct  = int'($urandom_range(30, 100));
      b_pct  = int'($urandom_range(30, 100));
      for (int c = 0; c < 50; c++) begin
        wr_valid   = $urandom_range(0, 1) == 1;
        wr_addr    = 32'h4000_0000 + (32'($urandom_range(0, 5)) << 2) + 32'($urandom_range(0, 3));
        wr_data    = $urandom;
        wr_strb    = 4'($urandom_range(1, 15));
        query_addr = 32'h4000_0000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
        step(acc);
      end
    end
    wr_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
